// File: rtl/sr_pulse_gen.sv
//------------------------------------------------------------------------------
// Module   : sr_pulse_gen
// Brief    : Synchronize, debounce and edge-detect set/clear requests into
//            single-cycle s/r pulses; clear has priority over set.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sr_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clk,
    input  logic r,
    input  logic set_in,
    input  logic clr_in,
    output logic s_out,
    output logic r_out,
    output logic set_lvl,
    output logic clr_lvl
);

    localparam int            c_CH       = 2;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel 0 carries the set request, channel 1 the clear request.
    logic [c_CH-1:0]            w_raw;
    logic [c_CH-1:0]            sync1_q;
    logic [c_CH-1:0]            sync2_q;
    logic [c_CH-1:0]            lvl_q;
    logic [c_CH-1:0]            lvl_d;
    logic [c_CH-1:0]            prev_q;
    logic [c_CH-1:0][CNT_W-1:0] cnt_q;
    logic [c_CH-1:0][CNT_W-1:0] cnt_d;
    logic [c_CH-1:0]            w_rise;
    logic                       s_out_q;
    logic                       s_out_d;
    logic                       r_out_q;
    logic                       r_out_d;

    assign w_raw = {clr_in, set_in};

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q;
        for (int ch = 0; ch < c_CH; ch++) begin
            if (sync2_q[ch] == lvl_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == c_CNT_LAST) begin
                lvl_d[ch] = sync2_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + 1'b1;
            end
        end
    end

    // Set is blocked by the debounced clear level so the pulses never overlap.
    always_comb begin
        w_rise  = lvl_q & ~prev_q;
        r_out_d = w_rise[1];
        s_out_d = w_rise[0] & ~lvl_q[1];
    end

    always_ff @(posedge clk) begin
        if (r) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
            s_out_q <= 1'b0;
            r_out_q <= 1'b0;
        end else begin
            sync1_q <= w_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            cnt_q   <= cnt_d;
            s_out_q <= s_out_d;
            r_out_q <= r_out_d;
        end
    end

    assign s_out   = s_out_q;
    assign r_out   = r_out_q;
    assign set_lvl = lvl_q[0];
    assign clr_lvl = lvl_q[1];

endmodule

`default_nettype wire

// File: tb/tb_sr_pulse_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_sr_pulse_gen
// Brief    : Directed and randomized checks of sr_pulse_gen against a
//            sample-history reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_pulse_gen;

    localparam int D = 4;

    logic clk = 1'b0;
    logic r;
    logic set_in;
    logic clr_in;
    logic s_out;
    logic r_out;
    logic set_lvl;
    logic clr_lvl;

    int checks = 0;
    int errors = 0;
    int s_cnt  = 0;
    int r_cnt  = 0;

    // Model state: raw-sample delay line, run length of samples disagreeing
    // with the debounced level, and whether the level rose at the last edge.
    bit m_s1   [2];
    bit m_s2   [2];
    bit m_lvl  [2];
    bit m_rose [2];
    int m_run  [2];
    bit m_s;
    bit m_r;

    sr_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk     (clk),
        .r       (r),
        .set_in  (set_in),
        .clr_in  (clr_in),
        .s_out   (s_out),
        .r_out   (r_out),
        .set_lvl (set_lvl),
        .clr_lvl (clr_lvl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rr, input bit raw_set, input bit raw_clr);
        bit raw [2];
        bit new_rose [2];
        raw[0] = raw_set;
        raw[1] = raw_clr;
        if (rr) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_lvl[c] = 0; m_rose[c] = 0; m_run[c] = 0;
            end
            m_s = 0;
            m_r = 0;
        end else begin
            m_r = m_rose[1];
            m_s = m_rose[0] && !m_lvl[1];
            for (int c = 0; c < 2; c++) begin
                new_rose[c] = 0;
                if (m_s2[c] != m_lvl[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_lvl[c]    = m_s2[c];
                        m_run[c]    = 0;
                        new_rose[c] = m_lvl[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_rose[c] = new_rose[c];
                m_s2[c]   = m_s1[c];
                m_s1[c]   = raw[c];
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge(r, set_in, clr_in);
            #1;
            chk("s_out", s_out, m_s);
            chk("r_out", r_out, m_r);
            chk("set_lvl", set_lvl, m_lvl[0]);
            chk("clr_lvl", clr_lvl, m_lvl[1]);
            chk("no_overlap", s_out & r_out, 1'b0);
            s_cnt += int'(s_out);
            r_cnt += int'(r_out);
        end
    endtask

    initial begin
        r = 1'b1; set_in = 1'b1; clr_in = 1'b1;

        // Reset with both inputs high
        for (int e = 1; e <= 3; e++) begin
            step(1);
            chk("rst_s", s_out, 1'b0);
            chk("rst_r", r_out, 1'b0);
            chk("rst_slvl", set_lvl, 1'b0);
            chk("rst_clvl", clr_lvl, 1'b0);
        end
        r = 1'b0; set_in = 1'b0; clr_in = 1'b0;
        step(8);

        // Clean set
        set_in = 1'b1; s_cnt = 0; r_cnt = 0;
        for (int e = 1; e <= 27; e++) begin
            step(1);
            if (e == 5) chk("clean_lvl_e5", set_lvl, 1'b0);
            if (e == 6) chk("clean_lvl_e6", set_lvl, 1'b1);
            chk("clean_s", s_out, logic'(e == 7));
        end
        chk_int("clean_r_cnt", r_cnt, 0);
        set_in = 1'b0;
        step(10);

        // Short glitch
        set_in = 1'b1; s_cnt = 0;
        step(3);
        set_in = 1'b0;
        step(10);
        chk("glitch_lvl", set_lvl, 1'b0);
        chk_int("glitch_s_cnt", s_cnt, 0);

        // Bounce then stable high
        s_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            set_in = logic'(i % 2 == 0);
            step(1);
        end
        chk_int("bounce_s_cnt", s_cnt, 0);
        set_in = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            step(1);
            chk("bounce_s", s_out, logic'(e == 7));
        end
        chk_int("bounce_total", s_cnt, 1);
        set_in = 1'b0;
        step(10);

        // Simultaneous set and clear
        set_in = 1'b1; clr_in = 1'b1; s_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (e == 6) begin
                chk("sim_slvl", set_lvl, 1'b1);
                chk("sim_clvl", clr_lvl, 1'b1);
            end
            chk("sim_r", r_out, logic'(e == 7));
        end
        chk_int("sim_s_cnt", s_cnt, 0);

        // Set pressed while clear held
        set_in = 1'b0;
        step(10);
        set_in = 1'b1; s_cnt = 0;
        step(12);
        chk("held_slvl", set_lvl, 1'b1);
        chk_int("held_s_cnt", s_cnt, 0);
        clr_in = 1'b0;
        step(10);
        set_in = 1'b0;
        step(10);
        set_in = 1'b1; s_cnt = 0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            chk("repress_s", s_out, logic'(e == 7));
        end
        chk_int("repress_cnt", s_cnt, 1);
        set_in = 1'b0;
        step(10);

        // Reset mid-count
        set_in = 1'b1; s_cnt = 0;
        step(4);
        r = 1'b1;
        step(1);
        r = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step(1);
            if (e == 5) chk("midrst_lvl_e5", set_lvl, 1'b0);
            chk("midrst_s", s_out, logic'(e == 7));
        end
        chk_int("midrst_cnt", s_cnt, 1);
        set_in = 1'b0;
        step(10);

        // Randomized hold lengths with occasional reset
        for (int k = 0; k < 150; k++) begin
            set_in = logic'($urandom_range(0, 1));
            clr_in = logic'($urandom_range(0, 1));
            r      = logic'($urandom_range(0, 19) == 0);
            step(1);
            r = 1'b0;
            step($urandom_range(0, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
